// File: rtl/data_mem_store.sv
// Store path into a word-wide data memory without byte enables.
// Word stores write directly; byte/halfword stores do a read-modify-write.
module data_mem_store #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  store_req_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [ADDR_WIDTH-1:0] write_data_i,
  input  logic [1:0]            mem_type_i,
  input  logic [ADDR_WIDTH-1:0] mem_rdata_i,
  output logic                  stall_o,
  output logic                  done_o,
  output logic                  misaligned_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_re_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_wdata_o
);

  localparam logic [1:0] MT_BYTE = 2'b01;
  localparam logic [1:0] MT_HALF = 2'b10;

  typedef enum logic [1:0] {IDLE, READ, MERGE, WRITE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] wdata_q;
  logic [ADDR_WIDTH-1:0] merge_q;
  logic [1:0]            off_q;
  logic [1:0]            type_q;

  logic                  req_vld;
  logic                  in_byte;
  logic                  in_half;
  logic                  misaligned;
  logic                  accept;
  logic                  word_q;
  logic [ADDR_WIDTH-1:0] merged;

  // Requests are ignored while reset is held so nothing is accepted or flagged.
  assign req_vld    = (state == IDLE) && store_req_i && !rst;
  assign in_byte    = (mem_type_i == MT_BYTE);
  assign in_half    = (mem_type_i == MT_HALF);
  assign misaligned = (in_half && addr_i[0]) ||
                      (!in_byte && !in_half && (addr_i[1:0] != 2'b00));
  assign accept     = req_vld && !misaligned;
  assign word_q     = (type_q != MT_BYTE) && (type_q != MT_HALF);

  // Lane merge of the freshly read word with the latched store data.
  always_comb begin
    merged = mem_rdata_i;
    if (type_q == MT_BYTE)
      merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    else if (type_q == MT_HALF)
      merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      off_q   <= 2'b00;
      type_q  <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
            off_q   <= addr_i[1:0];
            wdata_q <= write_data_i;
            type_q  <= mem_type_i;
            state   <= (in_byte || in_half) ? READ : WRITE;
          end
        end
        READ:  state <= MERGE;
        MERGE: begin
          merge_q <= merged;
          state   <= WRITE;
        end
        WRITE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory-side strobes are pure decodes of the state register.
  assign misaligned_o = req_vld && misaligned;
  assign stall_o      = accept || (state == READ) || (state == MERGE);
  assign mem_re_o     = (state == READ);
  assign mem_we_o     = (state == WRITE);
  assign done_o       = (state == WRITE);
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = word_q ? wdata_q : merge_q;

endmodule

// File: doc/data_mem_store.md
# data_mem_store

Store-side companion of the load extract path: takes a store from the memory stage (address, rs2 data, size) and commits it to a word-wide data memory that has no byte enables. Word stores write directly. Byte and halfword stores perform a read-modify-write: read the word, merge the new lane, write it back. The block stalls the pipeline while busy and flags misaligned stores.

## Interface
- ADDR_WIDTH, 32, address and data width.
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- store_req_i  in  1  store present in the memory stage.
- addr_i  in  ADDR_WIDTH  byte address of the store.
- write_data_i  in  ADDR_WIDTH  rs2 store data.
- mem_type_i  in  2  store size: 01 byte (SB), 10 halfword (SH), 00/11 word (SW).
- mem_rdata_i  in  ADDR_WIDTH  memory read data; synchronous, valid in the cycle after mem_re_o.
- stall_o  out  1  hold the pipeline.
- done_o  out  1  one-cycle pulse in the cycle the write commits.
- misaligned_o  out  1  store is misaligned and dropped.
- mem_addr_o  out  ADDR_WIDTH  word address {addr[31:2], 2'b00}.
- mem_re_o  out  1  memory read strobe.
- mem_we_o  out  1  memory write strobe.
- mem_wdata_o  out  ADDR_WIDTH  word to write.

## Operation
- State machine: IDLE, READ, MERGE, WRITE. Reset state is IDLE.
- In IDLE, each cycle with store_req_i=1 is evaluated. A request is misaligned when it is a halfword with addr[0]=1, or a word with addr[1:0]≠00.
- Misaligned request:
  - misaligned_o=1 combinationally in that cycle.
  - stall_o=0, no memory access, state stays IDLE.
- Accepted request:
  - At the edge, latch the word address, addr[1:0], write_data_i and mem_type_i.
  - Word goes to WRITE; byte or halfword goes to READ.
- READ: mem_re_o=1, mem_addr_o = latched word address. Always goes to MERGE.
- MERGE:
  - Capture mem_rdata_i into the merge register, then go to WRITE.
  - Byte: replace lane addr[1:0] (bits 8·k+7:8·k) with write_data[7:0]; keep the other lanes.
  - Half: addr[1]=0 replaces [15:0], addr[1]=1 replaces [31:16], using write_data[15:0].
- WRITE:
  - mem_we_o=1 and done_o=1.
  - mem_wdata_o = latched write_data for a word store, or the merged word for a sub-word store.
  - Always returns to IDLE. store_req_i is ignored in this cycle, because it is still the same instruction.
- All mem_* outputs, done_o and stall_o in non-IDLE states are decoded from the state register. Latched values drive mem_addr_o and mem_wdata_o.

## Timing
- Reset values:
  - state=IDLE.
  - stall_o, done_o, misaligned_o, mem_re_o and mem_we_o are all 0.
  - mem_addr_o=0, mem_wdata_o=0, latched registers=0.
- stall_o = (IDLE & store_req_i & aligned) | READ | MERGE. It is 0 in WRITE, so the pipeline advances as the write commits.
- Word store: cycle 0 IDLE (stall), cycle 1 WRITE. One stall cycle.
- Sub-word store: cycle 0 IDLE (stall), cycle 1 READ, cycle 2 MERGE, cycle 3 WRITE. Three stall cycles.
- Back-to-back stores: the next request is sampled in the IDLE cycle after WRITE. There is no extra bubble beyond that.
- Outside READ, mem_re_o=0. Outside WRITE, mem_we_o=0. Exactly one write per accepted store.
- Reset mid-operation:
  - rst is sampled at the edge, and the next state is IDLE with registers cleared.
  - A store in READ or MERGE is abandoned with no write.
  - If the current state is WRITE when rst is high, the write is still presented in that cycle, since outputs are state-decoded.
- store_req_i deasserting while busy has no effect; the latched store completes.

## Test plan
- Reset: hold rst 2 cycles with store_req_i=1 → all outputs 0, state stays IDLE, no mem_we_o.
- SW addr=0x100, data=0xDEADBEEF → stall_o=1 for one cycle, then mem_we_o=1, mem_addr_o=0x100, mem_wdata_o=0xDEADBEEF, done_o=1.
- SB addr=0x203, data=0x000000AB, memory word=0x11223344:
  - mem_re_o=1 at 0x200.
  - Write 0xAB223344 in cycle 3.
  - stall_o high cycles 0–2.
- SH addr=0x202, data=0x0000CAFE, memory word=0x11223344 → write 0xCAFE3344. Repeat with addr=0x200 → 0x1122CAFE.
- Misaligned SH addr=0x201 and SW addr=0x102 → misaligned_o=1 the same cycle, stall_o=0, no mem_re_o or mem_we_o.
- rst asserted during MERGE of an SB → next cycle IDLE, no mem_we_o. A following SW completes normally.
